// File: rtl/db_en_gen.sv
// Debounce + enable-pulse generator: 2-FF sync, tick-paced confirm FSM, clean level and edge pulses.
// Latency: 2 cycles sync, then K sample ticks (between (K-1)*2^N+1 and K*2^N cycles) to accept a change.
// Backpressure: none; free-running, pulses are single-cycle and never overlap.
//
// Ports:
//   clk       rising-edge system clock
//   reset_n   asynchronous active-low reset
//   sw        raw, bouncy, asynchronous switch input
//   db_level  debounced level, decoded straight from a state flop
//   rise_tick one-cycle pulse on accepted 0->1 change (drives downstream en)
//   fall_tick one-cycle pulse on accepted 1->0 change

module db_en_gen #(
  parameter int N = 19,  // tick every 2^N clk cycles
  parameter int K = 3    // consecutive stable ticks to accept a change, 1..15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(K + 1);

  // Encoding chosen so that bit 1 is the debounced level itself.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  state_t         state;
  logic           s1;
  logic           s2;
  logic [N-1:0]   tick_cnt;
  logic           tick;
  logic [CW-1:0]  conf_cnt;
  logic [CW-1:0]  conf_nxt;
  logic           conf_done;

  // Counter restarts at 0 on reset release, so the tick phase is deterministic.
  assign tick      = (tick_cnt == '1);
  assign conf_nxt  = conf_cnt + CW'(1);
  assign conf_done = (conf_nxt == CW'(K));
  assign db_level  = state[1];

  // Two-flop synchroniser; only s2 is ever looked at by the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + N'(1);
    end
  end

  // Confirmation FSM. The revert check sits ahead of the tick check so a
  // sample that flips back on the K-th tick cancels the transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ZERO;
      conf_cnt  <= '0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      case (state)
        ZERO: begin
          if (s2) begin
            state    <= WAIT1;
            conf_cnt <= '0;
          end
        end
        WAIT1: begin
          if (!s2) begin
            state <= ZERO;
          end else if (tick) begin
            if (conf_done) begin
              state     <= ONE;
              rise_tick <= 1'b1;
            end else begin
              conf_cnt <= conf_nxt;
            end
          end
        end
        ONE: begin
          if (!s2) begin
            state    <= WAIT0;
            conf_cnt <= '0;
          end
        end
        WAIT0: begin
          if (s2) begin
            state <= ONE;
          end else if (tick) begin
            if (conf_done) begin
              state     <= ZERO;
              fall_tick <= 1'b1;
            end else begin
              conf_cnt <= conf_nxt;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_db_en_gen.sv
// Bench for db_en_gen with N=4 (tick every 16 cycles) and K=3.
// Latency: n/a.
// Backpressure: n/a.

module tb_db_en_gen;

  localparam int NB = 4;
  localparam int KB = 3;
  localparam int P  = 1 << NB;

  logic clk = 1'b0;
  logic reset_n;
  logic sw;
  logic db_level;
  logic rise_tick;
  logic fall_tick;
  logic q;

  int total = 0;
  int bad   = 0;

  // Reference model state: level, sync pipeline, disagreement run, ticks seen in run.
  logic m_s1, m_s2, m_level, m_run, m_rise, m_fall;
  int   m_ticks, m_cyc;

  always #5 clk = ~clk;

  db_en_gen #(.N(NB), .K(KB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw        (sw),
    .db_level  (db_level),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Downstream enable flop wired as a toggle (d = ~q).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= 1'b0;
    else if (rise_tick) q <= ~q;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the model, evaluated with the values present before the edge.
  task automatic model_step(input logic v);
    bit tk;
    if (!reset_n) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_ticks = 0;
      m_rise = 0; m_fall = 0; m_cyc = 0;
    end else begin
      tk = ((m_cyc % P) == P - 1);
      m_rise = 0;
      m_fall = 0;
      if (m_s2 != m_level) begin
        if (!m_run) begin
          m_run   = 1;
          m_ticks = 0;
        end else if (tk) begin
          m_ticks++;
          if (m_ticks == KB) begin
            m_level = m_s2;
            m_run   = 0;
            if (m_level) m_rise = 1; else m_fall = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = v;
      m_cyc++;
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic cyc(input logic v);
    sw = v;
    @(posedge clk);
    model_step(v);
    #1;
    chk("model", {29'd0, db_level, rise_tick, fall_tick}, {29'd0, m_level, m_rise, m_fall});
    @(negedge clk);
  endtask

  task automatic do_reset(input logic v);
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(v);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic v;
    int   len;
    int   rises;
    int   falls;
    logic lvl;
  } step_t;

  step_t tbl[9];

  initial begin
    int r, f, first;

    tbl[0] = '{1'b0, 20, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 60, 1, 0, 1'b1};
    tbl[2] = '{1'b0, 20, 0, 0, 1'b1};
    tbl[3] = '{1'b1, 10, 0, 0, 1'b1};
    tbl[4] = '{1'b0, 60, 0, 1, 1'b0};
    tbl[5] = '{1'b1,  5, 0, 0, 1'b0};
    tbl[6] = '{1'b0,  5, 0, 0, 1'b0};
    tbl[7] = '{1'b1, 25, 0, 0, 1'b0};
    tbl[8] = '{1'b0, 10, 0, 0, 1'b0};

    reset_n = 1'b0;
    sw      = 1'b0;
    m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_rise = 0; m_fall = 0;
    m_ticks = 0; m_cyc = 0;
    @(negedge clk);

    do_reset(1'b0);
    chk("reset_state", {29'd0, db_level, rise_tick, fall_tick}, 32'd0);

    // Table of holds: pulses and final level per step.
    foreach (tbl[s]) begin
      r = 0; f = 0;
      for (int j = 0; j < tbl[s].len; j++) begin
        cyc(tbl[s].v);
        r += int'(rise_tick);
        f += int'(fall_tick);
      end
      chk($sformatf("tbl%0d_rise", s), r, tbl[s].rises);
      chk($sformatf("tbl%0d_fall", s), f, tbl[s].falls);
      chk($sformatf("tbl%0d_lvl", s), {31'd0, db_level}, {31'd0, tbl[s].lvl});
    end

    // Clean step from cycle 10: WAIT1 entered at edge 12, pulse within 33..48 after that.
    do_reset(1'b0);
    r = 0; f = 0; first = -1;
    for (int e = 0; e < 70; e++) begin
      cyc(e >= 10);
      if (rise_tick && first < 0) first = e;
      r += int'(rise_tick);
      f += int'(fall_tick);
    end
    chk("step_rise_cnt", r, 1);
    chk("step_fall_cnt", f, 0);
    chk("step_window", {31'd0, (first >= 12 + 33) && (first <= 12 + 48)}, 32'd1);
    chk("step_lvl", {31'd0, db_level}, 32'd1);

    // Bounce: toggle every 5 cycles for 60 cycles, then hold 0.
    do_reset(1'b0);
    r = 0; f = 0;
    for (int e = 0; e < 100; e++) begin
      cyc((e < 60) ? logic'((e / 5) % 2) : 1'b0);
      r += int'(rise_tick);
      f += int'(fall_tick);
    end
    chk("bounce_pulses", r + f, 0);
    chk("bounce_lvl", {31'd0, db_level}, 32'd0);

    // Revert on the 3rd tick (edge 47): s2 seen low exactly then.
    do_reset(1'b0);
    r = 0;
    for (int e = 0; e < 80; e++) begin
      cyc((e >= 10) && (e < 45));
      r += int'(rise_tick);
    end
    chk("revert_rise", r, 0);
    chk("revert_lvl", {31'd0, db_level}, 32'd0);

    // One cycle later the 3rd tick still sees s2 high: rise lands on edge 47.
    do_reset(1'b0);
    first = -1;
    for (int e = 0; e < 80; e++) begin
      cyc((e >= 10) && (e < 46));
      if (rise_tick && first < 0) first = e;
    end
    chk("late_revert_rise_at", first, 47);

    // Release with a 3-cycle glitch mid-wait, then a real release.
    do_reset(1'b0);
    for (int e = 0; e < 60; e++) cyc(1'b1);
    r = 0; f = 0;
    for (int e = 0; e < 20; e++) cyc(1'b0);
    for (int e = 0; e < 3; e++) cyc(1'b1);
    for (int e = 0; e < 10; e++) begin
      cyc(1'b1);
      r += int'(rise_tick);
      f += int'(fall_tick);
    end
    chk("glitch_pulses", r + f, 0);
    chk("glitch_lvl", {31'd0, db_level}, 32'd1);
    f = 0;
    for (int e = 0; e < 60; e++) begin
      cyc(1'b0);
      f += int'(fall_tick);
    end
    chk("release_fall", f, 1);
    chk("release_lvl", {31'd0, db_level}, 32'd0);

    // Asynchronous clear from ONE, then abort a WAIT1 after two ticks.
    do_reset(1'b0);
    for (int e = 0; e < 60; e++) cyc(1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_clr", {29'd0, db_level, rise_tick, fall_tick}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1);
    reset_n = 1'b1;
    for (int e = 0; e < 40; e++) cyc(1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_outs", {29'd0, db_level, rise_tick, fall_tick}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1);
    reset_n = 1'b1;
    first = -1;
    for (int e = 0; e < 60; e++) begin
      cyc(1'b1);
      if (rise_tick && first < 0) first = e;
    end
    chk("rearm_rise_at", first, 47);

    // Downstream toggle flop: one toggle per accepted press.
    do_reset(1'b0);
    for (int p = 0; p < 4; p++) begin
      for (int e = 0; e < 60; e++) cyc(1'b1);
      for (int e = 0; e < 60; e++) cyc(1'b0);
      chk($sformatf("q_press%0d", p), {31'd0, q}, (p % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Random runs against the model (every cycle compared inside cyc).
    do_reset(1'b0);
    for (int k = 0; k < 50; k++) begin
      logic v;
      int   len;
      v   = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 70);
      for (int j = 0; j < len; j++) cyc(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/db_en_gen.md
Name: db_en_gen

Overview:
- Debounce and enable-pulse generator placed directly upstream of the enable-gated D flip-flop stage.
- Takes a raw, asynchronous mechanical input (switch/button) and synchronises it to clk.
- Filters bounce with a tick-paced confirmation FSM.
- Emits a clean level plus single-cycle rise/fall pulses; rise_tick drives the downstream flip-flop's en input directly.

Parameters:
- N, 19, width of free-running tick counter; one sample tick every 2^N clk cycles (about 10 ms at 50 MHz).
- K, 3, consecutive stable sample ticks required to accept a level change; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- sw  input  1  raw asynchronous input, bouncy.
- db_level  output  1  debounced level.
- rise_tick  output  1  one-cycle pulse on accepted 0->1 change; feeds downstream en.
- fall_tick  output  1  one-cycle pulse on accepted 1->0 change.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - sync stages=0, tick counter=0, confirm count=0, state=ZERO.
  - db_level=0, rise_tick=0, fall_tick=0.
  - Reset mid-operation aborts any confirmation in progress; no pulse is emitted.
- Synchroniser: 2-FF chain sw -> s1 -> s2. The FSM sees only s2, giving 2 cycles of sync latency.
- Tick counter:
  - N-bit, free-running, wraps from 2^N-1 to 0.
  - tick=1 combinationally when counter==2^N-1, exactly 1 cycle in every 2^N.
- Confirm count: ceil(log2(K+1)) bits; cleared on every entry to WAIT1/WAIT0.
- FSM states and transitions:
  - ZERO: db_level=0. s2=1 -> WAIT1, count cleared.
  - WAIT1: db_level=0.
    - s2=0 -> ZERO (bounce rejected, no pulse).
    - Else on tick, count+1. If count+1==K on that tick -> ONE, and rise_tick is registered high for the first cycle in ONE.
  - ONE: db_level=1. s2=0 -> WAIT0, count cleared.
  - WAIT0: db_level=1.
    - s2=1 -> ONE (no pulse).
    - Else on tick, count+1. If count+1==K -> ZERO, and fall_tick is registered high for the first cycle in ZERO.
- Simultaneous events: if s2 reverts in the same cycle as the K-th tick, the revert wins; no transition and no pulse.
- Outputs:
  - db_level is decoded from the state register (glitch-free).
  - rise_tick and fall_tick are registers, each high for exactly 1 cycle per accepted edge, never both high together.
  - Pulses are at least 2^N cycles apart when K>=1.
- Latency: with the sw change captured into s1 at edge e0, WAIT1 (or WAIT0) is entered at e2. db_level changes and the pulse is asserted between edge e2+(K-1)*2^N+1 and e2+K*2^N, depending on tick phase.
- Reset release: the counter starts at 0, so the first tick is at cycle 2^N-1 after release (deterministic phase for benches).

Test Plan:
- N=4, K=3, clean step: reset_n low 3 cycles then high; sw=1 held from cycle 10 -> db_level=1 and rise_tick=1 for exactly 1 cycle within 33..48 cycles after e2; fall_tick stays 0.
- Bounce rejection, N=4, K=3: sw toggles every 5 cycles for 60 cycles, then holds 0 -> db_level stays 0 and rise_tick/fall_tick never assert.
- Release: from db_level=1, sw=0 held -> fall_tick single pulse, db_level=0 in the same window; a glitch of sw=1 for 3 cycles mid-wait returns to ONE with no pulse.
- Simultaneous revert: force s2 to drop on the exact cycle of the 3rd tick in WAIT1 -> state returns to ZERO, no rise_tick.
- Reset mid-operation: assert reset_n=0 during WAIT1 after 2 ticks -> all outputs 0 immediately (asynchronous); after release, sw=1 requires a full K=3 ticks again.
- Downstream check: connect rise_tick to en of the enable D-FF with d=~q -> q toggles exactly once per accepted press over 4 presses (q sequence 1,0,1,0).
